// File: rtl/icram_bist_ctl.sv
// March-style BIST sequencer for the icache data RAM: W0, R0W1, R1W0 (descending), R0.
// Each 64-bit doubleword is written as two 32-bit halves; reads are compared one cycle later.
module icram_bist_ctl #(
  parameter int IC_MSB = 13
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              test_mode,
  input  logic [1:0]        bist_mode,
  input  logic              bist_reset,
  input  logic [63:0]       icram_dout,
  output logic [IC_MSB:3]   bist_icu_addr,
  output logic [31:0]       bist_icu_din,
  output logic [1:0]        bist_icu_ram_we,
  output logic              bist_enable,
  output logic              icache_test_err_l,
  output logic              bist_done
);

  localparam int AW = IC_MSB - 2;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] W0   = 3'd1;
  localparam logic [2:0] R0W1 = 3'd2;
  localparam logic [2:0] R1W0 = 3'd3;
  localparam logic [2:0] R0   = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  localparam logic [AW-1:0] ADDR_LAST = '1;
  localparam logic [31:0]   BG_SOLID  = '0;
  localparam logic [31:0]   BG_CHECK  = 32'h5555_5555;

  logic [2:0]    state, state_n;
  logic [AW-1:0] addr, addr_n;
  logic [1:0]    phase, phase_n;
  logic [31:0]   bg, bg_n;

  logic          en_n;
  logic [1:0]    we_n;
  logic [31:0]   din_n;
  logic [AW-1:0] oaddr_n;

  logic          cmp_active;
  logic [63:0]   cmp_exp;

  // Sequencer: phase counts the cycles spent on the current address.
  always_comb begin
    state_n = state;
    addr_n  = addr;
    phase_n = phase;
    bg_n    = bg;
    case (state)
      IDLE: begin
        if (test_mode && (bist_mode != 2'b00)) begin
          state_n = W0;
          addr_n  = '0;
          phase_n = '0;
          bg_n    = (bist_mode == 2'b10) ? BG_CHECK : BG_SOLID;
        end
      end
      W0: begin
        if (phase == 2'd1) begin
          phase_n = '0;
          if (addr == ADDR_LAST) begin
            state_n = R0W1;
            addr_n  = '0;
          end else begin
            addr_n = addr + AW'(1);
          end
        end else begin
          phase_n = phase + 2'd1;
        end
      end
      R0W1: begin
        if (phase == 2'd2) begin
          phase_n = '0;
          if (addr == ADDR_LAST) begin
            state_n = R1W0;
            addr_n  = ADDR_LAST;
          end else begin
            addr_n = addr + AW'(1);
          end
        end else begin
          phase_n = phase + 2'd1;
        end
      end
      R1W0: begin
        if (phase == 2'd2) begin
          phase_n = '0;
          if (addr == '0) begin
            state_n = R0;
            addr_n  = '0;
          end else begin
            addr_n = addr - AW'(1);
          end
        end else begin
          phase_n = phase + 2'd1;
        end
      end
      R0: begin
        if (phase == 2'd1) begin
          phase_n = '0;
          if (addr == ADDR_LAST) begin
            state_n = DONE;
            addr_n  = '0;
          end else begin
            addr_n = addr + AW'(1);
          end
        end else begin
          phase_n = phase + 2'd1;
        end
      end
      DONE: begin
        state_n = DONE;
      end
      default: begin
        state_n = IDLE;
        addr_n  = '0;
        phase_n = '0;
      end
    endcase

    if (!test_mode) begin
      state_n = IDLE;
      addr_n  = '0;
      phase_n = '0;
    end
    if (bist_reset) begin
      state_n = IDLE;
      addr_n  = '0;
      phase_n = '0;
    end
  end

  // Output values are decoded from the next state so the registered outputs line up with it.
  always_comb begin
    en_n    = 1'b0;
    we_n    = 2'b00;
    din_n   = '0;
    oaddr_n = addr_n;
    case (state_n)
      W0: begin
        en_n  = 1'b1;
        din_n = bg_n;
        we_n  = (phase_n == 2'd0) ? 2'b01 : 2'b10;
      end
      R0W1, R1W0: begin
        en_n = 1'b1;
        if (phase_n != 2'd0) begin
          din_n = (state_n == R0W1) ? ~bg_n : bg_n;
          we_n  = (phase_n == 2'd1) ? 2'b01 : 2'b10;
        end
      end
      R0: begin
        en_n = (phase_n == 2'd0);
      end
      default: begin
        oaddr_n = '0;
      end
    endcase
  end

  // Read data for the phase-0 read arrives during phase 1 of the same address.
  always_comb begin
    cmp_active = (phase == 2'd1) &&
                 ((state == R0W1) || (state == R1W0) || (state == R0));
    cmp_exp    = (state == R1W0) ? {~bg, ~bg} : {bg, bg};
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state             <= IDLE;
      addr              <= '0;
      phase             <= '0;
      bg                <= '0;
      bist_icu_addr     <= '0;
      bist_icu_din      <= '0;
      bist_icu_ram_we   <= 2'b00;
      bist_enable       <= 1'b0;
      bist_done         <= 1'b0;
      icache_test_err_l <= 1'b1;
    end else begin
      state           <= state_n;
      addr            <= addr_n;
      phase           <= phase_n;
      bg              <= bg_n;
      bist_icu_addr   <= oaddr_n;
      bist_icu_din    <= din_n;
      bist_icu_ram_we <= we_n;
      bist_enable     <= en_n;
      bist_done       <= (state_n == DONE);
      if (bist_reset) begin
        icache_test_err_l <= 1'b1;
      end else if (cmp_active && (icram_dout != cmp_exp)) begin
        icache_test_err_l <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_icram_bist_ctl.sv
// Randomised scoreboard bench for icram_bist_ctl with a behavioural 1-cycle-read RAM.
module tb_icram_bist_ctl;

  localparam int IC_MSB = 5;
  localparam int N      = 8;

  typedef struct {
    int         rel;
    logic [1:0] we;
    logic [2:0] addr;
    logic [31:0] din;
  } acc_t;

  logic          clk = 1'b0;
  logic          reset_l;
  logic          test_mode;
  logic [1:0]    bist_mode;
  logic          bist_reset;
  logic [63:0]   icram_dout = '0;
  logic [IC_MSB:3] bist_icu_addr;
  logic [31:0]   bist_icu_din;
  logic [1:0]    bist_icu_ram_we;
  logic          bist_enable;
  logic          icache_test_err_l;
  logic          bist_done;

  icram_bist_ctl #(.IC_MSB(IC_MSB)) dut (
    .clk              (clk),
    .reset_l          (reset_l),
    .test_mode        (test_mode),
    .bist_mode        (bist_mode),
    .bist_reset       (bist_reset),
    .icram_dout       (icram_dout),
    .bist_icu_addr    (bist_icu_addr),
    .bist_icu_din     (bist_icu_din),
    .bist_icu_ram_we  (bist_icu_ram_we),
    .bist_enable      (bist_enable),
    .icache_test_err_l(icache_test_err_l),
    .bist_done        (bist_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  acc_t q[$];
  int   err_rel, done_rel, start_cyc, mon_end;
  bit   mon_on;
  logic [63:0] mmem [N];

  bit          init_req;
  bit          stuck_en;
  logic [2:0]  stuck_addr;
  logic [63:0] stuck_mask;

  // Behavioural RAM; stuck bit forces a 1 on read of one address.
  logic [63:0] ram [N];
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < N; i++) ram[i] <= {$urandom, $urandom};
    end else if (bist_enable) begin
      if (bist_icu_ram_we == 2'b00)
        icram_dout <= ram[bist_icu_addr] |
                      ((stuck_en && bist_icu_addr == stuck_addr) ? stuck_mask : 64'h0);
      else begin
        if (bist_icu_ram_we[0]) ram[bist_icu_addr][31:0]  <= bist_icu_din;
        if (bist_icu_ram_we[1]) ram[bist_icu_addr][63:32] <= bist_icu_din;
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic check_quiet(input string nm, input logic e);
    check(nm, {bist_enable, bist_icu_ram_we, bist_icu_din, bist_icu_addr, bist_done, icache_test_err_l},
              {1'b0, 2'b00, 32'h0, 3'b000, 1'b0, e});
  endtask

  function automatic int cur_rel();
    return cyc - start_cyc + 1;
  endfunction

  function automatic logic err_exp(input int r);
    return !(err_rel != 0 && r >= err_rel);
  endfunction

  function automatic logic [31:0] bg_of(input logic [1:0] m);
    return (m == 2'b10) ? 32'h5555_5555 : 32'h0000_0000;
  endfunction

  // Reference model: March element list, each access tagged with its cycle number.
  task automatic mw(input int r, input logic [1:0] we, input logic [2:0] a, input logic [31:0] d);
    q.push_back('{r, we, a, d});
    if (we[0]) mmem[a][31:0]  = d;
    if (we[1]) mmem[a][63:32] = d;
  endtask

  task automatic mr(input int r, input logic [2:0] a, input logic [63:0] exp_v);
    logic [63:0] v;
    v = mmem[a];
    if (stuck_en && a == stuck_addr) v = v | stuck_mask;
    if (v !== exp_v && err_rel == 0) err_rel = r + 2;
    q.push_back('{r, 2'b00, a, 32'h0});
  endtask

  task automatic build_model(input logic [31:0] bg);
    int r;
    q.delete();
    err_rel = 0;
    r = 1;
    for (int i = 0; i < N; i++) begin
      mw(r, 2'b01, 3'(i), bg); mw(r + 1, 2'b10, 3'(i), bg); r += 2;
    end
    for (int i = 0; i < N; i++) begin
      mr(r, 3'(i), {bg, bg}); mw(r + 1, 2'b01, 3'(i), ~bg); mw(r + 2, 2'b10, 3'(i), ~bg); r += 3;
    end
    for (int i = N - 1; i >= 0; i--) begin
      mr(r, 3'(i), {~bg, ~bg}); mw(r + 1, 2'b01, 3'(i), bg); mw(r + 2, 2'b10, 3'(i), bg); r += 3;
    end
    for (int i = 0; i < N; i++) begin
      mr(r, 3'(i), {bg, bg}); r += 2;
    end
    done_rel = r;
  endtask

  // Monitor: pops the scoreboard whenever an access is due and checks status flags every cycle.
  always @(negedge clk) begin : monitor
    int   rel;
    acc_t e;
    if (mon_on) begin
      rel = cyc - start_cyc + 1;
      if (rel >= 1 && rel <= mon_end) begin
        if (q.size() > 0 && q[0].rel == rel) begin
          e = q.pop_front();
          check("access_enable", bist_enable, 1);
          check("access_addr", bist_icu_addr, e.addr);
          check("access_we", bist_icu_ram_we, e.we);
          if (e.we != 2'b00) check("write_din", bist_icu_din, e.din);
        end else begin
          check("no_access", {bist_enable, bist_icu_ram_we}, 0);
        end
        if (rel >= done_rel) check("done_bus_zero", {bist_icu_addr, bist_icu_din}, 0);
        check("bist_done", bist_done, rel >= done_rel);
        check("err_l", icache_test_err_l, err_exp(rel));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rel(input int r);
    while (cur_rel() < r) step();
  endtask

  task automatic prep(input bit sa_en, input logic [2:0] sa, input int sb);
    bist_reset = 1'b1;
    init_req   = 1'b1;
    stuck_en   = sa_en;
    stuck_addr = sa;
    stuck_mask = 64'd1 << sb;
    step();
    bist_reset = 1'b0;
    init_req   = 1'b0;
  endtask

  task automatic arm(input logic [1:0] m);
    build_model(bg_of(m));
    bist_mode = m;
    test_mode = 1'b1;
    start_cyc = cyc + 1;
    mon_end   = 1 << 30;
    mon_on    = 1'b1;
  endtask

  task automatic finish_run();
    wait_rel(done_rel + 2);
    mon_end   = cur_rel();
    test_mode = 1'b0;
    bist_mode = 2'b00;
    step();
    mon_on = 1'b0;
    check_quiet("end_idle", err_exp(cur_rel()));
    check("all_accesses_seen", q.size(), 0);
  endtask

  task automatic run_plain(input logic [1:0] m, input bit sa_en, input logic [2:0] sa, input int sb);
    prep(sa_en, sa, sb);
    arm(m);
    finish_run();
  endtask

  initial begin
    int ab;
    reset_l = 1'b0; test_mode = 1'b0; bist_mode = 2'b00; bist_reset = 1'b0;
    init_req = 1'b0; stuck_en = 1'b0; stuck_addr = '0; stuck_mask = '0;
    mon_on = 1'b0; mon_end = 0; start_cyc = 0; err_rel = 0; done_rel = 0;
    repeat (3) step();
    check_quiet("reset_state", 1'b1);
    reset_l = 1'b1;
    step();

    // bist_mode=00 with test_mode=1 must never start
    prep(1'b0, 3'd0, 0);
    bist_mode = 2'b00;
    test_mode = 1'b1;
    repeat (10) begin
      step();
      check_quiet("mode00_idle", 1'b1);
    end
    test_mode = 1'b0;
    step();

    run_plain(2'b01, 1'b0, 3'd0, 0);
    run_plain(2'b10, 1'b0, 3'd0, 0);
    run_plain(2'b11, 1'b0, 3'd0, 0);
    run_plain(2'b01, 1'b1, 3'd3, 40);
    repeat (3) run_plain(2'($urandom_range(1, 3)), 1'b1, 3'($urandom_range(0, 7)), $urandom_range(0, 63));

    // bist_reset during R1W0 after an error, then clean restart
    prep(1'b1, 3'd1, $urandom_range(0, 63));
    arm(2'b01);
    ab = $urandom_range(41, 64);
    wait_rel(ab);
    mon_end = ab;
    bist_reset = 1'b1;
    step();
    bist_reset = 1'b0;
    mon_on = 1'b0;
    check_quiet("bist_reset_idle", 1'b1);
    stuck_en = 1'b0;
    arm(2'b01);
    finish_run();

    // test_mode dropped mid-W0
    prep(1'b0, 3'd0, 0);
    arm(2'b10);
    ab = $urandom_range(1, 16);
    wait_rel(ab);
    mon_end = ab;
    test_mode = 1'b0;
    bist_mode = 2'b00;
    step();
    mon_on = 1'b0;
    check_quiet("tm_drop_w0_idle", 1'b1);
    repeat (5) begin
      step();
      check("tm_drop_no_access", {bist_enable, bist_icu_ram_we}, 0);
    end

    // test_mode dropped during R0 keeps the sticky error
    prep(1'b1, 3'd0, $urandom_range(0, 63));
    arm(2'b01);
    ab = $urandom_range(66, 80);
    wait_rel(ab);
    mon_end = ab;
    test_mode = 1'b0;
    bist_mode = 2'b00;
    step();
    mon_on = 1'b0;
    check_quiet("tm_drop_err_kept", err_exp(ab + 1));

    // reset_l wins over bist_reset and test_mode
    prep(1'b1, 3'($urandom_range(0, 7)), $urandom_range(0, 63));
    arm(2'b01);
    ab = $urandom_range(50, 75);
    wait_rel(ab);
    mon_end = ab;
    reset_l = 1'b0;
    bist_reset = 1'b1;
    step();
    mon_on = 1'b0;
    check_quiet("reset_priority", 1'b1);
    reset_l = 1'b1;
    bist_reset = 1'b0;
    test_mode = 1'b0;
    bist_mode = 2'b00;
    step();
    check_quiet("post_reset_idle", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/icram_bist_ctl.md
ICRAM_BIST_CTL -- requirements
Module: icram_bist_ctl

Interface
REQ-001 The block SHALL have parameter IC_MSB, default 13, giving the MSB of the icache RAM doubleword address; entries N = 2^(IC_MSB-2).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_l, input, 1 bit, synchronous active-low reset, sampled on the clk rising edge.
REQ-004 The block SHALL have port test_mode, input, 1 bit, BIST enable; 0 aborts or inhibits a test.
REQ-005 The block SHALL have port bist_mode, input, 2 bits, pattern select: 00 none, 01 solid (bg=32'h0000_0000), 10 checker (bg=32'h5555_5555), 11 treated as 01.
REQ-006 The block SHALL have port bist_reset, input, 1 bit, synchronous test restart.
REQ-007 The block SHALL have port icram_dout, input, 64 bits, RAM read data, valid the cycle after a read is issued.
REQ-008 The block SHALL have port bist_icu_addr, output, IC_MSB-2 bits (bit IC_MSB down to 3), RAM address.
REQ-009 The block SHALL have port bist_icu_din, output, 32 bits, RAM write data.
REQ-010 The block SHALL have port bist_icu_ram_we, output, 2 bits; bit0 writes dout[31:0], bit1 writes dout[63:32].
REQ-011 The block SHALL have port bist_enable, output, 1 bit, high on every cycle it issues a RAM read or write.
REQ-012 The block SHALL have port icache_test_err_l, output, 1 bit, sticky fail flag, active-low.
REQ-013 The block SHALL have port bist_done, output, 1 bit, high while in DONE.

Function
REQ-014 The FSM SHALL have states IDLE, W0, R0W1, R1W0, R0, DONE.
REQ-015 IDLE SHALL go to W0 when test_mode=1 and bist_mode!=00; the pattern is latched at that edge and held until IDLE.
REQ-016 W0 SHALL sweep addresses 0 to N-1, 2 cycles each: we=01 then we=10, din=bg, enable=1 both cycles.
REQ-017 R0W1 SHALL sweep 0 to N-1, 3 cycles each: read (we=00, enable=1); compare icram_dout with {bg,bg} while writing ~bg with we=01; write ~bg with we=10.
REQ-018 R1W0 SHALL be identical to R0W1 but sweep N-1 down to 0, expect {~bg,~bg}, write bg.
REQ-019 R0 SHALL sweep 0 to N-1, 2 cycles each: read; compare with {bg,bg}, enable=0 on the compare cycle.
REQ-020 Each element SHALL advance to the next state on the last cycle of its final address; address counter wraps, with no idle gap; W0 entry is cycle 1, so DONE is entered 10N+1 cycles after the start edge.
REQ-021 DONE SHALL hold until test_mode=0 or bist_reset=1, then go to IDLE.
REQ-022 A compare mismatch in any bit SHALL drive icache_test_err_l low on the next cycle; it stays low until reset_l or bist_reset, and the sweep continues to DONE.
REQ-023 bist_reset=1 in any state SHALL force IDLE, address 0, and icache_test_err_l=1 on the next cycle, with priority over all other transitions.
REQ-024 test_mode=0 mid-test SHALL force IDLE on the next cycle; icache_test_err_l is preserved.
REQ-025 In IDLE and DONE the block SHALL drive bist_enable=0, bist_icu_ram_we=00, bist_icu_din=0, and bist_icu_addr=0.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 reset_l=0 SHALL force IDLE, address counter 0, bist_enable=0, bist_icu_ram_we=00, bist_icu_din=0, bist_icu_addr=0, icache_test_err_l=1, and bist_done=0.
REQ-028 reset_l SHALL take priority over bist_reset and test_mode.

Verification (IC_MSB=5, N=8, behavioural RAM with 1-cycle read)
REQ-029 Scenario: clean RAM, bist_mode=01 -> bist_done rises at cycle 81, icache_test_err_l stays 1, and the R1W0 addresses run 7 down to 0.
REQ-030 Scenario: bist_mode=10 -> W0 din=32'h5555_5555, R0W1 din=32'hAAAA_AAAA, with no error.
REQ-031 Scenario: RAM bit 40 stuck-at-1 at address 3 -> icache_test_err_l goes low the cycle after the R0W1 compare at address 3, and bist_done still rises at cycle 81.
REQ-032 Scenario: bist_reset pulsed during R1W0 -> IDLE the next cycle, err_l=1, and a restart completes 81 cycles later.
REQ-033 Scenario: test_mode dropped mid-W0, or bist_mode=00 with test_mode=1 -> IDLE with outputs quiescent, and no RAM access is issued.
REQ-034 Scenario: reset_l=0 asserted with bist_reset=1 and test_mode=1 -> all outputs at their REQ-027 values the next cycle.
